// File: rtl/gfx256_pixel_writer.sv
// gfx256_pixel_writer: gathers pixel writes of 8/16/24/32 bpp into one
// 32-byte line buffer and writes the whole line out as a single 256-bit
// bus write with byte enables.
//
// Pixel side handshake: a pixel is accepted on a rising clk_i edge where
// req_i & ready_o. Bus side: mem_cyc_o/mem_stb_o/mem_we_o stay high, and
// address/select/data stay stable, until the edge where mem_ack_i is seen.
//
// Optional feature: define GFX256_PW_TIMEOUT_EN to write out an open line
// automatically after TIMEOUT idle cycles in FILL.
module gfx256_pixel_writer #(
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   color_depth_i,
    input  logic         req_i,
    input  logic [31:0]  adr_i,
    input  logic [31:0]  color_i,
    output logic         ready_o,
    input  logic         flush_i,
    output logic         busy_o,
    output logic         mem_cyc_o,
    output logic         mem_stb_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_adr_o,
    output logic [31:0]  mem_sel_o,
    output logic [255:0] mem_dat_o,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [26:0]    line_q, line_d;
    logic [31:0]    sel_q, sel_d;
    logic [255:0]   dat_q, dat_d;

    logic [26:0]    req_line;
    logic           same_line;
    logic           accept;
    logic           timeout_hit;
    logic [3:0]     px_bytes;
    logic [255:0]   px_wmask;
    logic [31:0]    px_sel;
    logic [7:0]     px_mb;
    logic [255:0]   px_color;
    logic [255:0]   merge_base;
    logic [255:0]   merged;

    assign req_line  = adr_i[31:5];
    assign same_line = (req_line == line_q);
    assign accept    = req_i & ready_o;

    // Pixel decode: byte count, bit mask and placement inside the line.
    always_comb begin
        px_bytes = 4'h1;
        px_wmask = 256'h0;
        case (color_depth_i)
            2'd0: begin px_bytes = 4'h1; px_wmask = 256'hFF;       end
            2'd1: begin px_bytes = 4'h3; px_wmask = 256'hFFFF;     end
            2'd2: begin px_bytes = 4'h7; px_wmask = 256'hFFFFFF;   end
            default: begin px_bytes = 4'hF; px_wmask = 256'hFFFFFFFF; end
        endcase
        // Bytes shifted past the end of the line are simply dropped.
        px_sel     = {28'h0, px_bytes} << adr_i[4:0];
        px_mb      = {adr_i[4:0], 3'b000};
        px_color   = {224'h0, color_i} & px_wmask;
        // A fresh line starts from an empty buffer.
        merge_base = (state_q == ST_IDLE) ? 256'h0 : dat_q;
        merged     = (merge_base & ~(px_wmask << px_mb)) | (px_color << px_mb);
    end

`ifdef GFX256_PW_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Idle counter: zero outside FILL and on every accept, counts FILL cycles without accept.
    always_comb begin
        cnt_d = 8'h0;
        if (state_q == ST_FILL && !accept) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == TIMEOUT) && !accept;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: close the line on full select, flush, line change or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (flush_i || (sel_q == 32'hFFFF_FFFF) ||
                    (req_i && !same_line) || timeout_hit) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and bus strobes decoded from the current state.
    always_comb begin
        ready_o   = (state_q == ST_IDLE) || ((state_q == ST_FILL) && same_line);
        busy_o    = (state_q != ST_IDLE);
        mem_cyc_o = (state_q == ST_WRITE);
        mem_stb_o = (state_q == ST_WRITE);
        mem_we_o  = (state_q == ST_WRITE);
        mem_adr_o = {line_q, 5'b00000};
        mem_sel_o = sel_q;
        mem_dat_o = dat_q;
    end

    // Line buffer next value: merge accepted pixels, clear select once the write is acked.
    always_comb begin
        line_d = line_q;
        sel_d  = sel_q;
        dat_d  = dat_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                line_d = req_line;
                sel_d  = px_sel;
            end else begin
                sel_d  = sel_q | px_sel;
            end
            dat_d = merged;
        end
        if (state_q == ST_WRITE && mem_ack_i) begin
            sel_d = 32'h0;
        end
    end

    // Line buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= 27'h0;
            sel_q  <= 32'h0;
            dat_q  <= 256'h0;
        end else begin
            line_q <= line_d;
            sel_q  <= sel_d;
            dat_q  <= dat_d;
        end
    end

endmodule

// File: tb/tb_gfx256_pixel_writer.sv
// Directed testbench for gfx256_pixel_writer: full line, line change,
// overlap, flush with merge, timeout behaviour and mid-write reset.
module tb_gfx256_pixel_writer;

    logic         clk;
    logic         rst_n;
    logic [1:0]   color_depth_i;
    logic         req_i;
    logic [31:0]  adr_i;
    logic [31:0]  color_i;
    logic         ready_o;
    logic         flush_i;
    logic         busy_o;
    logic         mem_cyc_o;
    logic         mem_stb_o;
    logic         mem_we_o;
    logic [31:0]  mem_adr_o;
    logic [31:0]  mem_sel_o;
    logic [255:0] mem_dat_o;
    logic         mem_ack_i;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    gfx256_pixel_writer #(.TIMEOUT(8'd16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .color_depth_i (color_depth_i),
        .req_i         (req_i),
        .adr_i         (adr_i),
        .color_i       (color_i),
        .ready_o       (ready_o),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .mem_cyc_o     (mem_cyc_o),
        .mem_stb_o     (mem_stb_o),
        .mem_we_o      (mem_we_o),
        .mem_adr_o     (mem_adr_o),
        .mem_sel_o     (mem_sel_o),
        .mem_dat_o     (mem_dat_o),
        .mem_ack_i     (mem_ack_i)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Comparison helper.
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input logic [1:0] d, input logic [31:0] a, input logic [31:0] c);
        color_depth_i = d;
        adr_i         = a;
        color_i       = c;
        req_i         = 1'b1;
    endtask

    // Present one pixel, require it to be ready, and let one edge accept it.
    task automatic send_px(input string tag, input logic [1:0] d, input logic [31:0] a,
                           input logic [31:0] c);
        set_px(d, a, c);
        #1;
        chk({tag, ".ready"}, ready_o, 1'b1);
        tick();
        req_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    // Wait for a line write, check it, hold it two cycles unacked, then ack it.
    task automatic wait_write(input string tag, input logic [31:0] e_sel, input logic [255:0] e_dat);
        int k;
        logic [31:0] e_adr;
        k = 0;
        e_adr = 32'hFFFF_FFFF;
        if (exp_q.size() != 0) e_adr = exp_q.pop_front();
        while (!mem_stb_o && k < 40) begin
            tick();
            k++;
        end
        chk({tag, ".stb"}, mem_stb_o, 1'b1);
        chk({tag, ".cyc"}, mem_cyc_o, 1'b1);
        chk({tag, ".we"}, mem_we_o, 1'b1);
        chk({tag, ".adr"}, mem_adr_o, e_adr);
        chk({tag, ".sel"}, mem_sel_o, e_sel);
        chk({tag, ".dat"}, mem_dat_o, e_dat);
        chk({tag, ".ready_in_write"}, ready_o, 1'b0);
        chk({tag, ".busy_in_write"}, busy_o, 1'b1);
        tick();
        tick();
        chk({tag, ".stb_hold"}, mem_stb_o, 1'b1);
        chk({tag, ".adr_hold"}, mem_adr_o, e_adr);
        chk({tag, ".sel_hold"}, mem_sel_o, e_sel);
        chk({tag, ".dat_hold"}, mem_dat_o, e_dat);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk({tag, ".stb_drop"}, mem_stb_o, 1'b0);
        chk({tag, ".cyc_drop"}, mem_cyc_o, 1'b0);
        chk({tag, ".we_drop"}, mem_we_o, 1'b0);
        chk({tag, ".sel_clear"}, mem_sel_o, 32'h0);
        chk({tag, ".busy_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        logic [255:0] e_dat;
        logic         seen;

        rst_n         = 1'b0;
        color_depth_i = 2'd0;
        req_i         = 1'b0;
        adr_i         = 32'h0;
        color_i       = 32'h0;
        flush_i       = 1'b0;
        mem_ack_i     = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", ready_o, 1'b1);
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.cyc", mem_cyc_o, 1'b0);
        chk("rst.stb", mem_stb_o, 1'b0);
        chk("rst.we", mem_we_o, 1'b0);
        chk("rst.sel", mem_sel_o, 32'h0);
        chk("rst.adr", mem_adr_o, 32'h0);
        chk("rst.dat", mem_dat_o, 256'h0);
        rst_n = 1'b1;
        tick();

        // Flush in IDLE does nothing.
        pulse_flush();
        tick();
        chk("idle_flush.busy", busy_o, 1'b0);
        chk("idle_flush.stb", mem_stb_o, 1'b0);

        // Full line of 8bpp pixels, colour = low address byte.
        e_dat = 256'h0;
        for (int n = 0; n < 32; n++) begin
            send_px("full", 2'd0, 32'h100 + n, 32'h100 + n);
            e_dat[n*8 +: 8] = 8'(n);
        end
        chk("full.busy", busy_o, 1'b1);
        chk("full.stb_not_yet", mem_stb_o, 1'b0);
        tick();
        chk("full.stb_next_cycle", mem_stb_o, 1'b1);
        exp_q.push_back(32'h100);
        wait_write("full", 32'hFFFF_FFFF, e_dat);

        // Line change: second pixel is refused in FILL and taken after the ack.
        send_px("chg1", 2'd3, 32'h204, 32'hAABB_CCDD);
        set_px(2'd3, 32'h240, 32'h1122_3344);
        #1;
        chk("chg.ready_other_line", ready_o, 1'b0);
        tick();
        exp_q.push_back(32'h200);
        wait_write("chg_a", 32'h0000_00F0, 256'hAABB_CCDD << 32);
        chk("chg.ready_after_ack", ready_o, 1'b1);
        tick();
        req_i = 1'b0;
        chk("chg.busy_after_accept", busy_o, 1'b1);
        pulse_flush();
        exp_q.push_back(32'h240);
        wait_write("chg_b", 32'h0000_000F, 256'h1122_3344);

        // Overlap: later 8bpp pixel replaces the low byte of the 16bpp one.
        send_px("ovl1", 2'd1, 32'h300, 32'h0000_1234);
        send_px("ovl2", 2'd0, 32'h300, 32'h0000_0056);
        pulse_flush();
        chk("ovl.stb_latency", mem_stb_o, 1'b1);
        exp_q.push_back(32'h300);
        wait_write("ovl", 32'h0000_0003, 256'h1256);

        // Flush with a same-line 24bpp pixel in the same cycle.
        send_px("fm1", 2'd0, 32'h41D, 32'h0000_0011);
        set_px(2'd2, 32'h41D, 32'h00AB_CDEF);
        flush_i = 1'b1;
        #1;
        chk("fm.ready", ready_o, 1'b1);
        tick();
        req_i   = 1'b0;
        flush_i = 1'b0;
        exp_q.push_back(32'h400);
        wait_write("fm", 32'hE000_0000, 256'hAB_CDEF << 232);

        // Timeout behaviour for a lone pixel.
        send_px("to", 2'd0, 32'h500, 32'h0000_0077);
        seen = 1'b0;
`ifdef GFX256_PW_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            tick();
            if (mem_stb_o) seen = 1'b1;
        end
        chk("to.no_early_stb", seen, 1'b0);
        tick();
        chk("to.stb_at_17", mem_stb_o, 1'b1);
`else
        for (int k = 0; k < 100; k++) begin
            tick();
            if (mem_stb_o) seen = 1'b1;
        end
        chk("to.no_write_100", seen, 1'b0);
        chk("to.still_busy", busy_o, 1'b1);
        pulse_flush();
`endif
        exp_q.push_back(32'h500);
        wait_write("to", 32'h0000_0001, 256'h77);

        // Reset while a write is pending and unacknowledged.
        send_px("rstw", 2'd3, 32'h600, 32'hDEAD_BEEF);
        pulse_flush();
        chk("rstw.stb_pending", mem_stb_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw.ready", ready_o, 1'b1);
        chk("rstw.busy", busy_o, 1'b0);
        chk("rstw.cyc", mem_cyc_o, 1'b0);
        chk("rstw.stb", mem_stb_o, 1'b0);
        chk("rstw.we", mem_we_o, 1'b0);
        chk("rstw.sel", mem_sel_o, 32'h0);
        chk("rstw.adr", mem_adr_o, 32'h0);
        chk("rstw.dat", mem_dat_o, 256'h0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_stb_o || busy_o) seen = 1'b1;
        end
        chk("rstw.no_writeback", seen, 1'b0);
        chk("scoreboard.empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gfx256_pixel_writer.md
GFX256_PIXEL_WRITER -- requirements
Module: gfx256_pixel_writer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd16: idle cycles in FILL before the line is written out automatically.
REQ-002 SHALL have ports, clock and reset first: clk_i in 1, rising-edge clock; rst_ni in 1, reset.
REQ-003 SHALL use one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-004 SHALL have pixel-side ports:
- color_depth_i in 2: 0=8, 1=16, 2=24, 3=32 bpp.
- req_i in 1: pixel write request.
- adr_i in 32: pixel byte address.
- color_i in 32: pixel colour, LSB-aligned.
- ready_o out 1: pixel accepted when req_i & ready_o.
- flush_i in 1: force write-out of the open line.
- busy_o out 1: line open or bus cycle pending.
REQ-005 SHALL have memory-side ports:
- mem_cyc_o out 1, mem_stb_o out 1, mem_we_o out 1.
- mem_adr_o out 32: line address, low 5 bits zero.
- mem_sel_o out 32: byte enables.
- mem_dat_o out 256: line data.
- mem_ack_i in 1: write acknowledge.

Function
REQ-006 SHALL form line = adr_i[31:5], mb = {adr_i[4:0],3'b000}, pixel byte mask = (1,3,7,F for depth 0..3) << adr_i[4:0], truncated to 32 bits.
REQ-007 SHALL merge on accept: data bits [mb +: width] replaced by color_i masked to width (truncated above bit 255); sel |= pixel mask; the later pixel wins on overlap.
REQ-008 SHALL implement states IDLE, FILL and WRITE; ready_o = 1 in IDLE, 1 in FILL only when the req_i line equals the open line, and 0 in WRITE.
REQ-009 IDLE: on accept, SHALL latch the line, clear the buffer, merge the pixel and go to FILL; flush_i SHALL be a no-op.
REQ-010 FILL, a req_i with a different line SHALL NOT be accepted; the state SHALL go to WRITE and the pixel SHALL be accepted after return to IDLE.
REQ-011 FILL, SHALL go to WRITE the cycle after sel becomes 32'hFFFFFFFF.
REQ-012 FILL, on flush_i SHALL go to WRITE; a same-line req_i in the same cycle SHALL be merged first and included in the write.
REQ-013 WRITE: SHALL hold cyc/stb/we = 1 and adr/sel/dat stable until mem_ack_i; on ack SHALL drop cyc/stb/we the next cycle, clear sel and go to IDLE.
REQ-014 SHALL keep write latency from the FILL→WRITE decision to mem_stb_o at one cycle; back-to-back lines SHALL give ≥1 idle bus cycle between writes.
REQ-015 SHALL assert busy_o in FILL and WRITE and deassert it in IDLE.
REQ-016 SHALL never issue a write with sel = 0.

Reset
REQ-017 SHALL, on rst_ni low: state IDLE, ready_o 1, busy_o 0, mem_cyc_o/mem_stb_o/mem_we_o 0, mem_sel_o 0, mem_adr_o 0, mem_dat_o 0, timeout counter 0.
REQ-018 SHALL discard a pending bus cycle or open line when reset occurs mid-operation; no write-back after reset.

Configuration
REQ-019 SHALL use macro GFX256_PW_TIMEOUT_EN.
- Defined: an 8-bit counter clears on every accept and on entry to FILL, increments each FILL cycle without accept, and on reaching TIMEOUT the state SHALL go to WRITE.
- Undefined: no counter; the line SHALL be written only on full sel, line change or flush_i.

Verification
REQ-020 SHALL cover full line: 32 accepts of 8bpp, adr 0x100..0x11F, colour = adr[7:0] -> one write, adr 0x100, sel FFFFFFFF, dat byte n = n.
REQ-021 SHALL cover line change: 32bpp 0xAABBCCDD at 0x204, then 0x11223344 at 0x240 -> write adr 0x200, sel 0x000000F0; second pixel accepted after ack, then flush -> write adr 0x240, sel 0x0000000F.
REQ-022 SHALL cover overlap: 16bpp 0x1234 then 8bpp 0x56 at 0x300, flush -> sel 0x3, dat[15:0] = 0x1256.
REQ-023 SHALL cover flush with merge: 24bpp 0x00ABCDEF at 0x41D with flush_i in the same cycle in FILL -> sel 0xE0000000, dat[255:232] = ABCDEF.
REQ-024 SHALL cover timeout (macro defined, TIMEOUT = 16): one pixel, then idle -> mem_stb_o rises 17 cycles after accept; with the macro undefined -> no write within 100 cycles.
REQ-025 SHALL cover reset: rst_ni low while mem_stb_o = 1 and mem_ack_i withheld -> all outputs at reset values asynchronously; no write after release.
